// File: rtl/div_32_pkg.sv
// Shared constants, types and helpers for the iterative signed divider.
package div_32_pkg;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    localparam int          DIV_ITERS = 32;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;

    typedef struct packed {
        logic div0;
        logic ovf;
    } exc_class_t;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] x);
        return x[31] ? neg32(x) : x;
    endfunction

endpackage

// File: rtl/adder_32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups chained on group carries.
module adder_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] c;
    logic [7:0]  gg;
    logic [7:0]  gp;
    logic [8:0]  gc;

    assign g = a & b;
    assign p = a ^ b;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_grp
            localparam int B = gi * 4;
            assign gg[gi] = g[B+3]
                          | (p[B+3] & g[B+2])
                          | (p[B+3] & p[B+2] & g[B+1])
                          | (p[B+3] & p[B+2] & p[B+1] & g[B]);
            assign gp[gi] = &p[B+3:B];
        end
    endgenerate

    always_comb begin
        gc    = '0;
        c     = '0;
        gc[0] = cin;
        for (int k = 0; k < 8; k++) begin
            gc[k+1] = gg[k] | (gp[k] & gc[k]);
        end
        c[0] = gc[0];
        for (int i = 1; i < 32; i++) begin
            c[i] = ((i % 4) == 0) ? gc[i/4] : (g[i-1] | (p[i-1] & c[i-1]));
        end
    end

    assign sum  = p ^ c;
    assign cout = gc[8];

endmodule

// File: rtl/div_32.sv
// Multi-cycle signed 32-bit restoring divider; one trial subtraction per clock.
module div_32
    import div_32_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic             sgn_quo_q, sgn_quo_d;
    logic             sgn_rem_q, sgn_rem_d;
    exc_class_t       exc_q, exc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             exc_out_q, exc_out_d;
    logic             rdy_q, rdy_d;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] dvsr_n;
    logic [WIDTH-1:0] trial_sum;
    logic             trial_cout;
    logic             trial_ok;

    // The partial remainder is always below the divisor, so the shifted value fits in 33 bits.
    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign dvsr_n = ~dvsr_q;

    adder_32 u_trial (
        .a    (rem_sh[WIDTH-1:0]),
        .b    (dvsr_n),
        .cin  (1'b1),
        .sum  (trial_sum),
        .cout (trial_cout)
    );

    assign trial_ok = rem_sh[WIDTH] | trial_cout;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        dvsr_d      = dvsr_q;
        opa_d       = opa_q;
        sgn_quo_d   = sgn_quo_q;
        sgn_rem_d   = sgn_rem_q;
        exc_d       = exc_q;
        result_d    = result_q;
        remainder_d = remainder_q;
        exc_out_d   = exc_out_q;
        rdy_d       = 1'b0;

        if (ctrl_DIV) begin
            // A new start always wins, including over a run that is about to finish.
            state_d   = RUN;
            cnt_d     = '0;
            quo_d     = abs32(data_operandA);
            rem_d     = '0;
            dvsr_d    = abs32(data_operandB);
            opa_d     = data_operandA;
            sgn_quo_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            sgn_rem_d = data_operandA[WIDTH-1];
            exc_d.div0 = (data_operandB == '0);
            exc_d.ovf  = (data_operandA == INT_MIN) && (data_operandB == '1);
        end else begin
            case (state_q)
                RUN: begin
                    if (cnt_q == CNT_W'(DIV_ITERS)) begin
                        state_d = DONE;
                        rdy_d   = 1'b1;
                        if (exc_q.div0) begin
                            result_d    = '0;
                            remainder_d = opa_q;
                            exc_out_d   = 1'b1;
                        end else if (exc_q.ovf) begin
                            result_d    = INT_MIN;
                            remainder_d = '0;
                            exc_out_d   = 1'b1;
                        end else begin
                            result_d    = sgn_quo_q ? neg32(quo_q) : quo_q;
                            remainder_d = sgn_rem_q ? neg32(rem_q) : rem_q;
                            exc_out_d   = 1'b0;
                        end
                    end else begin
                        quo_d = {quo_q[WIDTH-2:0], trial_ok};
                        rem_d = trial_ok ? trial_sum : rem_sh[WIDTH-1:0];
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            dvsr_q      <= '0;
            opa_q       <= '0;
            sgn_quo_q   <= 1'b0;
            sgn_rem_q   <= 1'b0;
            exc_q       <= '0;
            result_q    <= '0;
            remainder_q <= '0;
            exc_out_q   <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            dvsr_q      <= dvsr_d;
            opa_q       <= opa_d;
            sgn_quo_q   <= sgn_quo_d;
            sgn_rem_q   <= sgn_rem_d;
            exc_q       <= exc_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
            exc_out_q   <= exc_out_d;
            rdy_q       <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_remainder = remainder_q;
    assign data_exception = exc_out_q;
    assign data_resultRDY = rdy_q;
    assign busy           = (state_q == RUN);

endmodule

// File: doc/div_32.md
Name: div_32

Overview:
- Multi-cycle 32-bit signed integer divider for the processor's multdiv path.
- It is the inverse companion to the 32-bit CLA adder: iterative restoring division by repeated trial subtraction.
- Each trial subtraction is done on one adder_32 instance, computing A + ~B + 1.
- The pipeline stalls on data_resultRDY; the divider returns quotient, remainder and an exception flag after a fixed latency.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported (adder_32 is fixed width).
- CNT_W, 6, iteration counter width; holds 0..WIDTH.

Ports:
- clock  input  1  single system clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- ctrl_DIV  input  1  start pulse; operands are sampled on the edge where this is 1.
- data_operandA  input  32  dividend, two's complement.
- data_operandB  input  32  divisor, two's complement.
- data_result  output  32  quotient, truncated toward zero.
- data_remainder  output  32  remainder; same sign as dividend, or 0.
- data_exception  output  1  divide-by-zero or signed overflow.
- data_resultRDY  output  1  one-cycle pulse; outputs are valid from this cycle.
- busy  output  1  high in RUN.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE; counter=0.
  - data_result=0, data_remainder=0, data_exception=0, data_resultRDY=0, busy=0.
  - Everything holds while reset_n is low.
- States: IDLE, RUN, DONE.
- Transitions:
  - IDLE --ctrl_DIV--> RUN.
  - RUN --(counter==32)--> DONE.
  - DONE --> IDLE, or DONE --> RUN if ctrl_DIV is 1 in DONE.
- Load edge (ctrl_DIV=1, any state):
  - Latch |A| into the quotient shift register and |B| into the divisor register.
  - Clear the 33-bit partial remainder; counter=0.
  - Latch sign flags: sign_q=A[31]^B[31], sign_r=A[31].
  - Latch exception class: div0 = (B==0); ovf = (A==0x80000000 && B==0xFFFFFFFF).
  - |0x80000000| is 0x80000000, treated as unsigned magnitude.
- RUN, one iteration per edge, 32 edges total:
  - Shift {rem,quo} left by 1.
  - trial = rem - divisor, computed by adder_32 (B inverted, Cin=1).
  - If trial is non-negative (carry out / bit 32 clear): rem=trial, quo[0]=1; else keep rem, quo[0]=0.
  - counter increments.
- DONE entry edge (33rd edge after load) registers the outputs:
  - data_result = sign_q ? -quo : quo.
  - data_remainder = sign_r ? -rem : rem.
  - div0: data_result=0, data_remainder=data_operandA as latched, data_exception=1.
  - ovf: data_result=0x80000000, data_remainder=0, data_exception=1.
  - Otherwise data_exception=0.
  - data_resultRDY=1 for exactly that one cycle.
- Latency:
  - Fixed 33 rising edges from the sampling edge to RDY high.
  - Independent of operand values, including the exception cases.
- Hold: data_result, data_remainder and data_exception hold until the next DONE entry or reset. RDY stays 0 outside DONE.
- ctrl_DIV during RUN:
  - Aborts the current operation and restarts with the new operands.
  - Exactly one RDY, 33 edges after the latest start; no RDY for the aborted op.
- ctrl_DIV in the DONE cycle: RDY still pulses for the finishing op; the new op loads on the same edge.
- Operands only need to be stable on the sampling edge.
- Reset mid-RUN: immediate return to the reset values; no RDY is issued for the aborted op.

Decomposition:
- Shared package:
  - State encoding constants: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - DIV_ITERS=32.
  - INT_MIN=32'h80000000.
- Sub-module: reuse adder_32 for the trial subtract.
- Negation and absolute value may use a second adder_32 instance (~X + 1) or a shared one muxed at load/done.

Test Plan:
- 100/7 (0x64/0x7), start at edge N -> RDY only at edge N+33; result=14 (0xE), remainder=2, exception=0, busy high edges N..N+32.
- -100/7 (0xFFFFFF9C/0x7) -> result=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2), exception=0.
- 5/0 -> result=0, remainder=5, exception=1, RDY still at N+33.
- 0x80000000/0xFFFFFFFF -> result=0x80000000, remainder=0, exception=1; also 0x80000000/2 -> 0xC0000000, exception=0.
- Start 1000/3, then at iteration 10 pulse ctrl_DIV with 9/3 -> single RDY 33 edges after the second start, result=3, remainder=0.
- Start 1000/3, drop reset_n asynchronously at iteration 10 -> outputs 0, busy 0 immediately, no RDY; after release, 21/-4 -> result=0xFFFFFFFB (-5), remainder=1.
